// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM encodings, width defaults, bubble
// instruction and a counter helper.
package fetch_stage_pkg;

    localparam int unsigned FE_INSTR_WIDTH = 32;
    localparam int unsigned FE_PC_WIDTH    = 28;
    localparam logic [31:0] FE_NOP_INSTR   = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DISC = 2'd3
    } fetch_state_e;

    // Free-running 32-bit event counter step; wraps naturally at 2^32.
    function automatic logic [31:0] fe_cnt_inc(input logic [31:0] cnt, input logic en);
        return en ? (cnt + 32'd1) : cnt;
    endfunction

endpackage

// File: rtl/fetch_stage_hold_buf.sv
// One-entry capture register for an instruction that returned while decode was stalled.
module fetch_hold_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Capture on load; a load in the same cycle as clear wins.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS fetch stage: owns the PC, keeps one imem request in flight, registers instruction/PCs
// for decode. Define FETCH_PERF_CNT_EN to add o_fetch_cnt / o_stall_cnt performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned            INSTR_WIDTH = FE_INSTR_WIDTH,
    parameter int unsigned            PC_WIDTH    = FE_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(FE_NOP_INSTR)
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    output logic                   o_imem_req,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    input  logic                   i_imem_valid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    input  logic                   i_stall_en,
    input  logic                   i_jmp_en,
    input  logic [PC_WIDTH-1:0]    i_pc_jmp,
    input  logic                   i_fe_kill,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [PC_WIDTH-1:0]    o_pc_fe,
    output logic [PC_WIDTH-1:0]    o_pc_fe_de,
    output logic                   o_valid_fe
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            o_fetch_cnt,
    output logic [31:0]            o_stall_cnt
`endif
);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_inc_s;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    pc_fe_q, pc_fe_d;
    logic [PC_WIDTH-1:0]    pc_fe_de_q, pc_fe_de_d;
    logic                   valid_q, valid_d;
    logic                   deliver_s, load_s;
    logic [INSTR_WIDTH-1:0] deliver_instr_s;
    logic                   hold_load_s, hold_clear_s, hold_vld_s;
    logic [INSTR_WIDTH-1:0] hold_data_s;

    assign pc_inc_s = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    fetch_hold_buf #(
        .WIDTH (INSTR_WIDTH)
    ) u_hold_buf (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .load_i   (hold_load_s),
        .clear_i  (hold_clear_s),
        .data_i   (i_imem_rdata),
        .data_o   (hold_data_s),
        .valid_o  (hold_vld_s)
    );

    // Fetch FSM, PC update and hold-buffer control; a redirect overrides every state.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        deliver_s       = 1'b0;
        deliver_instr_s = i_imem_rdata;
        hold_load_s     = 1'b0;
        hold_clear_s    = 1'b0;
        if (i_jmp_en) begin
            pc_d         = i_pc_jmp;
            hold_clear_s = 1'b1;
            // A request still in flight must be drained before fetching the target.
            if ((state_q == S_REQ) || ((state_q != S_HOLD) && !i_imem_valid)) begin
                state_d = S_DISC;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (i_imem_valid && i_stall_en) begin
                        hold_load_s = 1'b1;
                        state_d     = S_HOLD;
                    end else if (i_imem_valid) begin
                        deliver_s = 1'b1;
                        pc_d      = pc_inc_s;
                        state_d   = S_REQ;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!i_stall_en) begin
                        deliver_s       = hold_vld_s;
                        deliver_instr_s = hold_data_s;
                        hold_clear_s    = 1'b1;
                        pc_d            = pc_inc_s;
                        state_d         = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_DISC: begin
                    if (i_imem_valid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DISC;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    assign load_s = deliver_s & ~i_fe_kill;

    // Fetch->decode register: load, hold under stall, otherwise a bubble with PCs kept.
    always_comb begin
        instr_d    = instr_q;
        pc_fe_d    = pc_fe_q;
        pc_fe_de_d = pc_fe_de_q;
        valid_d    = valid_q;
        if (load_s) begin
            instr_d    = deliver_instr_s;
            pc_fe_d    = pc_inc_s;
            pc_fe_de_d = pc_q;
            valid_d    = 1'b1;
        end else if (i_stall_en && !i_jmp_en && !i_fe_kill) begin
            valid_d = valid_q;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // FSM state and PC registers.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Decode-facing output register.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            instr_q    <= NOP_INSTR;
            pc_fe_q    <= '0;
            pc_fe_de_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_fe_q    <= pc_fe_d;
            pc_fe_de_q <= pc_fe_de_d;
            valid_q    <= valid_d;
        end
    end

    // Request strobe is silenced while reset is held so nothing is issued before the PC is valid.
    assign o_imem_req    = (state_q == S_REQ) & i_arst_n;
    assign o_imem_addr   = pc_q;
    assign o_instruction = instr_q;
    assign o_pc_fe       = pc_fe_q;
    assign o_pc_fe_de    = pc_fe_de_q;
    assign o_valid_fe    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Delivered-instruction and stalled-valid-cycle counters.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fe_cnt_inc(fetch_cnt_q, load_s);
            stall_cnt_q <= fe_cnt_inc(stall_cnt_q, i_stall_en & valid_q);
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
